// File: rtl/stream_decrypt.sv
// Receive-side LFSR stream decryptor: valid/ready input, one stage register,
// output FIFO. Keystream advances only on accepted bytes to stay seed-aligned.
module stream_decrypt #(
  parameter logic [7:0]  SEED  = 8'hCD,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load_seed,
  input  logic [7:0]       i_seed_in,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [7:0]       i_data_in,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [7:0]       o_data_out,
  output logic [CNT_W-1:0] o_byte_cnt,
  output logic             o_busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {StIdle, StActive} state_e;

  function automatic logic [7:0] poly(input logic [7:0] p);
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
  endfunction

  state_e           r_state;
  state_e           w_state_next;
  logic [7:0]       r_prng;
  logic             r_stage_valid;
  logic [7:0]       r_stage_data;
  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [CNT_W-1:0] r_byte_cnt;

  logic [7:0]       w_ks;
  logic [CW:0]      w_occ;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_cnt_clr;

  assign w_ks        = poly(r_prng);
  // Stage plus FIFO occupancy: never accept a byte that has no FIFO slot reserved.
  assign w_occ       = {1'b0, r_count} + {{CW{1'b0}}, r_stage_valid};
  assign o_in_ready  = !i_load_seed && (w_occ < (CW + 1)'(DEPTH));
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_push      = r_stage_valid;
  assign o_out_valid = (r_count != '0);
  assign w_pop       = o_out_valid && i_out_ready;
  assign o_data_out  = r_mem[r_rptr];
  assign o_byte_cnt  = r_byte_cnt;
  assign o_busy      = r_stage_valid || (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_accept)    w_state_next = StActive;
      StActive: if (i_load_seed) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // In IDLE the counter is already zero, so a clear is only needed from ACTIVE.
  always_comb begin
    w_cnt_clr = (r_state == StActive) && i_load_seed;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prng        <= SEED;
      r_stage_valid <= 1'b0;
      r_stage_data  <= 8'h00;
      r_byte_cnt    <= '0;
    end else begin
      if (i_load_seed)   r_prng <= i_seed_in;
      else if (w_accept) r_prng <= w_ks;
      r_stage_valid <= w_accept;
      if (w_accept) r_stage_data <= i_data_in ^ w_ks;
      if (w_cnt_clr)     r_byte_cnt <= '0;
      else if (w_accept) r_byte_cnt <= r_byte_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= 8'h00;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= r_stage_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_decrypt.sv
// Bench for stream_decrypt: directed vectors plus a queue-based reference model
// checked every cycle on the falling edge.
module tb_stream_decrypt;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
  localparam logic [7:0]  SEED  = 8'hCD;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_load_seed = 1'b0;
  logic [7:0]       i_seed_in = 8'h00;
  logic             i_in_valid = 1'b0;
  logic             o_in_ready;
  logic [7:0]       i_data_in = 8'h00;
  logic             o_out_valid;
  logic             i_out_ready = 1'b0;
  logic [7:0]       o_data_out;
  logic [CNT_W-1:0] o_byte_cnt;
  logic             o_busy;

  always #5 clk = ~clk;

  stream_decrypt #(.SEED(SEED), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_load_seed (i_load_seed),
    .i_seed_in   (i_seed_in),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_data_in   (i_data_in),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_data_out  (o_data_out),
    .o_byte_cnt  (o_byte_cnt),
    .o_busy      (o_busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endfunction

  function automatic logic [7:0] lfsr(input logic [7:0] p);
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
  endfunction

  // Reference model: each accepted byte becomes an expected plaintext entry
  // tagged with the cycle it was accepted; it may appear two edges later.
  logic [7:0] m_prng;
  int         m_cnt = 0;
  int         m_cyc = 0;
  logic [7:0] exp_data[$];
  int         exp_cyc[$];
  logic [7:0] out_log[$];

  always @(negedge clk) begin
    int   occ;
    logic rdy;
    logic exp_v;
    m_cyc++;
    if (rst) begin
      chk("rst_out_valid", int'(o_out_valid), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_byte_cnt", int'(o_byte_cnt), 0);
      chk("rst_in_ready", int'(o_in_ready), 1);
      m_prng = SEED;
      m_cnt  = 0;
      exp_data.delete();
      exp_cyc.delete();
    end else begin
      occ   = exp_data.size();
      rdy   = !i_load_seed && (occ < int'(DEPTH));
      exp_v = (occ > 0) && (m_cyc - exp_cyc[0] >= 2);
      chk("in_ready", int'(o_in_ready), int'(rdy));
      chk("busy", int'(o_busy), int'(occ != 0));
      chk("byte_cnt", int'(o_byte_cnt), m_cnt % (1 << CNT_W));
      chk("out_valid", int'(o_out_valid), int'(exp_v));
      if (exp_v) begin
        chk("data_out", int'(o_data_out), int'(exp_data[0]));
        if (i_out_ready) begin
          out_log.push_back(o_data_out);
          void'(exp_data.pop_front());
          void'(exp_cyc.pop_front());
        end
      end
      if (i_load_seed) begin
        m_prng = i_seed_in;
        m_cnt  = 0;
      end else if (i_in_valid && rdy) begin
        m_prng = lfsr(m_prng);
        exp_data.push_back(i_data_in ^ m_prng);
        exp_cyc.push_back(m_cyc);
        m_cnt++;
      end
    end
  end

  logic rnd = 1'b0;

  task automatic send(input logic [7:0] b);
    logic acc;
    i_in_valid = 1'b1;
    i_data_in  = b;
    for (int t = 0; t < 200; t++) begin
      if (rnd) i_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = o_in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        i_in_valid = 1'b0;
        return;
      end
    end
    i_in_valid = 1'b0;
    chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      if (rnd) i_out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!o_busy) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("drain_timeout", 0, 1);
  endtask

  task automatic load(input logic [7:0] s);
    i_load_seed = 1'b1;
    i_seed_in   = s;
    @(posedge clk);
    #1;
    i_load_seed = 1'b0;
  endtask

  initial begin
    logic [7:0] enc;
    logic [7:0] pt;
    logic [7:0] pt_q[$];
    int         n_acc;

    repeat (2) @(posedge clk);
    #1;
    rst         = 1'b0;
    i_out_ready = 1'b1;

    // 1: back-to-back bytes, latency 2
    out_log.delete();
    send(8'h9A);
    chk("t1_valid_after_e0", int'(o_out_valid), 0);
    send(8'h35);
    chk("t1_valid_after_e1", int'(o_out_valid), 1);
    drain();
    chk("t1_cnt", int'(o_byte_cnt), 2);
    chk("t1_n", out_log.size(), 2);
    chk("t1_b0", int'(out_log[0]), 8'h00);
    chk("t1_b1", int'(out_log[1]), 8'h00);

    // 2: seed load
    load(8'h01);
    out_log.delete();
    send(8'h43);
    drain();
    chk("t2_data", int'(out_log[0]), 8'h41);
    chk("t2_cnt", int'(o_byte_cnt), 1);

    // 3: back-pressure fills exactly DEPTH
    out_log.delete();
    i_out_ready = 1'b0;
    i_in_valid  = 1'b1;
    i_data_in   = 8'h10;
    n_acc       = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_in_ready) n_acc++;
      @(posedge clk);
      #1;
      i_data_in = i_data_in + 8'h11;
    end
    i_in_valid = 1'b0;
    chk("t3_accepted", n_acc, int'(DEPTH));
    chk("t3_ready_full", int'(o_in_ready), 0);
    i_out_ready = 1'b1;
    drain();
    chk("t3_n", out_log.size(), int'(DEPTH));
    chk("t3_cnt", int'(o_byte_cnt), 5);

    // 4: seed load with bytes in flight
    out_log.delete();
    i_out_ready = 1'b0;
    send(8'h11);
    send(8'h22);
    i_load_seed = 1'b1;
    i_seed_in   = 8'h01;
    i_in_valid  = 1'b1;
    i_data_in   = 8'h43;
    @(negedge clk);
    chk("t4_ready_on_load", int'(o_in_ready), 0);
    @(posedge clk);
    #1;
    i_load_seed = 1'b0;
    send(8'h43);
    i_out_ready = 1'b1;
    drain();
    chk("t4_n", out_log.size(), 3);
    chk("t4_new_seed_byte", int'(out_log[2]), 8'h41);
    chk("t4_cnt", int'(o_byte_cnt), 1);

    // 5: reset mid-stream
    i_out_ready = 1'b0;
    send(8'h01);
    send(8'h02);
    send(8'h03);
    chk("t5_pre_valid", int'(o_out_valid), 1);
    rst = 1'b1;
    #1;
    chk("t5_out_valid", int'(o_out_valid), 0);
    chk("t5_busy", int'(o_busy), 0);
    chk("t5_cnt", int'(o_byte_cnt), 0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    i_out_ready = 1'b1;
    out_log.delete();
    send(8'h9A);
    drain();
    chk("t5_after_rst", int'(out_log[0]), 8'h00);

    // 6: encryptor loopback with random stalls, counter wraps at 16
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_log.delete();
    enc = SEED;
    rnd = 1'b1;
    for (int i = 0; i < 600; i++) begin
      pt  = 8'($urandom);
      enc = lfsr(enc);
      pt_q.push_back(pt);
      idle($urandom_range(0, 2));
      send(pt ^ enc);
    end
    rnd         = 1'b0;
    i_out_ready = 1'b1;
    drain();
    chk("t6_cnt_wrap", int'(o_byte_cnt), 600 % 16);
    chk("t6_n", out_log.size(), pt_q.size());
    for (int i = 0; i < pt_q.size() && i < out_log.size(); i++)
      chk("t6_plaintext", int'(out_log[i]), int'(pt_q[i]));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
